// File: rtl/spi_peripheral_burst.sv
// SPI peripheral with burst register access: one command word (rw + address) followed by any
// number of data words while spi_cs_n stays low. SPI pins are oversampled on clk.
module spi_peripheral_burst #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned ADDR_W      = 7,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              ena,
  input  logic              spi_clk,
  input  logic              spi_cs_n,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              auto_inc,
  input  logic [ADDR_W:0]   status,
  output logic [ADDR_W-1:0] addr,
  output logic              wr_rdn,
  output logic              we,
  output logic [DATA_W-1:0] wdata,
  output logic              re,
  input  logic [DATA_W-1:0] rdata,
  output logic              frame_active,
  output logic              frame_err
);

  localparam int unsigned CMD_W = ADDR_W + 1;
  localparam int unsigned TX_W  = (CMD_W > DATA_W) ? CMD_W : DATA_W;
  localparam int unsigned CNT_W = $clog2(TX_W + 1);
  localparam logic [CNT_W-1:0] CmdLast  = CNT_W'(CMD_W - 1);
  localparam logic [CNT_W-1:0] DataLast = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {StIdle, StCmd, StWdata, StRdata} state_e;

  state_e state_q, state_d;

  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sclk_prev_q, sclk_prev_d;
  logic                   cs_prev_q, cs_prev_d;

  logic sclk_s, cs_s, mosi_s;
  logic sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic lead_edge, trail_edge, sample, change;

  logic              cpol_q, cpol_d;
  logic              cpha_q, cpha_d;
  logic              auto_inc_q, auto_inc_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [TX_W-2:0]   rx_q, rx_d;
  logic [TX_W-1:0]   rx_shift;
  logic [TX_W-1:0]   tx_q, tx_d;
  logic [DATA_W-1:0] pend_q, pend_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wr_rdn_q, wr_rdn_d;
  logic              we_q, we_d;
  logic              re_q, re_d;
  logic              cap_q, cap_d;
  logic              active_q, active_d;
  logic              oe_q, oe_d;
  logic              err_q, err_d;

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign cs_rise   = cs_s & ~cs_prev_q;
  assign cs_fall   = ~cs_s & cs_prev_q;

  assign lead_edge  = cpol_q ? sclk_fall : sclk_rise;
  assign trail_edge = cpol_q ? sclk_rise : sclk_fall;
  // cs_rise implies cs_s high, so end of frame always beats a coincident sample edge.
  assign sample = (state_q != StIdle) & ~cs_s & (cpha_q ? trail_edge : lead_edge);
  assign change = (state_q != StIdle) & ~cs_s & (cpha_q ? lead_edge : trail_edge);

  assign rx_shift = {rx_q, mosi_s};

  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], spi_clk};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
    sclk_prev_d = sclk_s;
    cs_prev_d   = cs_s;

    state_d    = state_q;
    cpol_d     = cpol_q;
    cpha_d     = cpha_q;
    auto_inc_d = auto_inc_q;
    bit_cnt_d  = bit_cnt_q;
    rx_d       = rx_q;
    tx_d       = tx_q;
    pend_d     = pend_q;
    wdata_d    = wdata_q;
    addr_d     = addr_q;
    wr_rdn_d   = wr_rdn_q;
    we_d       = 1'b0;
    re_d       = 1'b0;
    cap_d      = re_q;
    active_d   = active_q;
    oe_d       = oe_q;
    err_d      = 1'b0;

    // Register bank returns rdata the clk after re.
    if (cap_q) pend_d = rdata;
    if (we_q && auto_inc_q) addr_d = addr_q + ADDR_W'(1);

    if (state_q == StIdle) begin
      if (cs_fall) begin
        state_d    = StCmd;
        cpol_d     = cpol;
        cpha_d     = cpha;
        auto_inc_d = auto_inc;
        bit_cnt_d  = '0;
        rx_d       = '0;
        pend_d     = '0;
        tx_d       = TX_W'(status) << (TX_W - CMD_W);
        active_d   = 1'b1;
        oe_d       = 1'b1;
      end
    end else if (cs_rise) begin
      state_d  = StIdle;
      active_d = 1'b0;
      oe_d     = 1'b0;
      tx_d     = '0;
      err_d    = (bit_cnt_q != '0);
    end else begin
      if (sample) begin
        rx_d      = rx_shift[TX_W-2:0];
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
        case (state_q)
          StCmd: begin
            if (bit_cnt_q == CmdLast) begin
              addr_d    = rx_shift[ADDR_W-1:0];
              wr_rdn_d  = rx_shift[CMD_W-1];
              bit_cnt_d = '0;
              state_d   = rx_shift[CMD_W-1] ? StWdata : StRdata;
              re_d      = ~rx_shift[CMD_W-1];
            end
          end
          StWdata: begin
            if (bit_cnt_q == DataLast) begin
              wdata_d   = rx_shift[DATA_W-1:0];
              we_d      = 1'b1;
              bit_cnt_d = '0;
            end
          end
          StRdata: begin
            if (bit_cnt_q == DataLast) begin
              addr_d    = addr_q + ADDR_W'(auto_inc_q);
              re_d      = 1'b1;
              bit_cnt_d = '0;
            end
          end
          default: ;
        endcase
      end
      // A change edge at bit_cnt 0 is a word boundary for both CPHA settings.
      if (change) begin
        if (bit_cnt_q != '0) begin
          tx_d = tx_q << 1;
        end else begin
          case (state_q)
            StRdata: tx_d = TX_W'(pend_q) << (TX_W - DATA_W);
            StWdata: tx_d = '0;
            default: tx_d = tx_q;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      state_q <= StIdle;
    end else if (ena) begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '0;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b0;
      cpol_q      <= 1'b0;
      cpha_q      <= 1'b0;
      auto_inc_q  <= 1'b0;
      bit_cnt_q   <= '0;
      rx_q        <= '0;
      tx_q        <= '0;
      pend_q      <= '0;
      wdata_q     <= '0;
      addr_q      <= '0;
      wr_rdn_q    <= 1'b0;
      we_q        <= 1'b0;
      re_q        <= 1'b0;
      cap_q       <= 1'b0;
      active_q    <= 1'b0;
      oe_q        <= 1'b0;
      err_q       <= 1'b0;
    end else if (ena) begin
      sclk_sync_q <= sclk_sync_d;
      cs_sync_q   <= cs_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sclk_prev_q <= sclk_prev_d;
      cs_prev_q   <= cs_prev_d;
      cpol_q      <= cpol_d;
      cpha_q      <= cpha_d;
      auto_inc_q  <= auto_inc_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      pend_q      <= pend_d;
      wdata_q     <= wdata_d;
      addr_q      <= addr_d;
      wr_rdn_q    <= wr_rdn_d;
      we_q        <= we_d;
      re_q        <= re_d;
      cap_q       <= cap_d;
      active_q    <= active_d;
      oe_q        <= oe_d;
      err_q       <= err_d;
    end
  end

  assign spi_miso     = tx_q[TX_W-1];
  assign spi_miso_oe  = oe_q;
  assign addr         = addr_q;
  assign wr_rdn       = wr_rdn_q;
  assign we           = we_q;
  assign wdata        = wdata_q;
  assign re           = re_q;
  assign frame_active = active_q;
  assign frame_err    = err_q;

endmodule
